// File: rtl/lsb_queue.sv
// rtl/lsb_queue.sv - load/store buffer: in-order memory access queue with ROB commit and flush
// Define LSB_TRACE_EN to print every memory completion.

module lsb_queue #(
  parameter int ROB_WIDTH = 4,
  parameter int LSB_WIDTH = 3,
  parameter int LSB_SIZE  = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 from_issue,
  input  logic [ROB_WIDTH-1:0] from_issue_tag,
  input  logic                 from_issue_store,
  input  logic [2:0]           from_issue_funct3,
  input  logic [31:0]          from_issue_addr,
  input  logic [31:0]          from_issue_sdata,
  output logic                 to_issue_full,
  input  logic                 from_rob_commit,
  input  logic [ROB_WIDTH-1:0] from_rob_commit_tag,
  output logic                 to_rob,
  output logic [ROB_WIDTH-1:0] to_rob_tag,
  output logic [31:0]          to_rob_wdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [1:0]           mem_width,
  input  logic                 mem_done,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_WAIT, S_LOAD_HELD, S_STORE_WAIT} state_t;

  localparam logic [LSB_WIDTH-1:0] PTR_ONE  = LSB_WIDTH'(1);
  localparam logic [LSB_WIDTH-1:0] FULL_LVL = LSB_WIDTH'(LSB_SIZE - 1);

  logic [ROB_WIDTH-1:0] r_tag    [LSB_SIZE];
  logic [2:0]           r_funct3 [LSB_SIZE];
  logic [31:0]          r_addr   [LSB_SIZE];
  logic [31:0]          r_sdata  [LSB_SIZE];
  logic [LSB_SIZE-1:0]  r_store;
  logic [LSB_SIZE-1:0]  r_rep;

  logic [LSB_WIDTH-1:0] r_head, r_cptr, r_tail;
  logic                 r_full, r_kill;
  state_t               r_state, w_state_next;
  logic                 r_to_rob;
  logic [ROB_WIDTH-1:0] r_to_rob_tag, r_cur_tag;
  logic [31:0]          r_to_rob_wdata, r_mem_addr, r_mem_wdata;
  logic                 r_mem_req, r_mem_we;
  logic [1:0]           r_mem_width;
  logic [2:0]           r_cur_funct3;

  logic                 w_accept, w_commit, w_head_drop, w_mem_fin;
  logic                 w_start_load, w_start_store, w_dequeue, w_load_rep, w_kill_set;
  logic                 w_st_found;
  logic [LSB_WIDTH-1:0] w_cptr_next, w_tail_next, w_head_next, w_occ_next, w_pend, w_k, w_st_idx;
  logic [31:0]          w_ext;

  assign w_accept    = from_issue && !clear && !r_full;
  assign w_commit    = from_rob_commit && (r_cptr != r_tail) && (from_rob_commit_tag == r_tag[r_cptr]);
  assign w_cptr_next = w_commit ? r_cptr + PTR_ONE : r_cptr;
  assign w_tail_next = clear ? w_cptr_next : (w_accept ? r_tail + PTR_ONE : r_tail);
  assign w_head_next = w_dequeue ? r_head + PTR_ONE : r_head;
  assign w_occ_next  = w_tail_next - w_head_next;
  assign w_pend      = r_tail - r_cptr;
  // Head entry is uncommitted and about to be flushed this cycle.
  assign w_head_drop = clear && (r_head == w_cptr_next) && (r_head != r_tail);
  assign w_mem_fin   = mem_done && ((r_state == S_LOAD_WAIT) || (r_state == S_STORE_WAIT));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else if (rdy_in) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_start_load  = 1'b0;
    w_start_store = 1'b0;
    w_dequeue     = 1'b0;
    w_load_rep    = 1'b0;
    w_kill_set    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_head != r_tail) && !w_head_drop) begin
          if (!r_store[r_head]) begin
            w_start_load = 1'b1;
            w_state_next = S_LOAD_WAIT;
          end else if (r_head != r_cptr) begin
            w_start_store = 1'b1;
            w_state_next  = S_STORE_WAIT;
          end
        end
      end
      S_LOAD_WAIT: begin
        if (mem_done) begin
          w_load_rep   = !(r_kill || w_head_drop);
          w_state_next = (r_kill || w_head_drop) ? S_IDLE : S_LOAD_HELD;
        end else if (w_head_drop) begin
          w_kill_set = 1'b1;
        end
      end
      S_LOAD_HELD: begin
        if (w_head_drop) begin
          w_state_next = S_IDLE;
        end else if (r_head != r_cptr) begin
          w_dequeue    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_STORE_WAIT: begin
        if (mem_done) begin
          w_dequeue    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Oldest uncommitted store not yet reported to the ROB.
  always_comb begin
    w_st_found = 1'b0;
    w_st_idx   = r_cptr;
    w_k        = r_cptr;
    for (int k = 0; k < LSB_SIZE; k++) begin
      w_k = r_cptr + LSB_WIDTH'(k);
      if (!w_st_found && (LSB_WIDTH'(k) < w_pend) && r_store[w_k] && !r_rep[w_k]) begin
        w_st_found = 1'b1;
        w_st_idx   = w_k;
      end
    end
    if (clear) w_st_found = 1'b0;
  end

  always_comb begin
    case (r_cur_funct3)
      3'b000:  w_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  w_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  w_ext = {24'd0, mem_rdata[7:0]};
      3'b101:  w_ext = {16'd0, mem_rdata[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && w_accept) begin
      r_tag[r_tail]    <= from_issue_tag;
      r_funct3[r_tail] <= from_issue_funct3;
      r_addr[r_tail]   <= from_issue_addr;
      r_sdata[r_tail]  <= from_issue_sdata;
      r_store[r_tail]  <= from_issue_store;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head         <= '0;
      r_cptr         <= '0;
      r_tail         <= '0;
      r_full         <= 1'b0;
      r_rep          <= '0;
      r_kill         <= 1'b0;
      r_to_rob       <= 1'b0;
      r_to_rob_tag   <= '0;
      r_to_rob_wdata <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_width    <= '0;
      r_cur_tag      <= '0;
      r_cur_funct3   <= '0;
    end else if (rdy_in) begin
      r_head <= w_head_next;
      r_cptr <= w_cptr_next;
      r_tail <= w_tail_next;
      r_full <= (w_occ_next >= FULL_LVL);
      if (w_accept) r_rep[r_tail] <= 1'b0;
      r_to_rob <= 1'b0;
      if (w_load_rep) begin
        r_to_rob       <= 1'b1;
        r_to_rob_tag   <= r_cur_tag;
        r_to_rob_wdata <= w_ext;
        r_rep[r_head]  <= 1'b1;
      end else if (w_st_found) begin
        r_to_rob        <= 1'b1;
        r_to_rob_tag    <= r_tag[w_st_idx];
        r_to_rob_wdata  <= '0;
        r_rep[w_st_idx] <= 1'b1;
      end
      if (w_start_load || w_start_store) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= w_start_store;
        r_mem_addr   <= r_addr[r_head];
        r_mem_wdata  <= w_start_store ? r_sdata[r_head] : 32'd0;
        r_mem_width  <= r_funct3[r_head][1:0];
        r_cur_tag    <= r_tag[r_head];
        r_cur_funct3 <= r_funct3[r_head];
      end else if (w_mem_fin) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
      if (w_kill_set) r_kill <= 1'b1;
      else if (w_mem_fin) r_kill <= 1'b0;
    end
  end

`ifdef LSB_TRACE_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && w_mem_fin)
      $display("lsb_queue: %s tag=%0d addr=%h data=%h", r_mem_we ? "store" : "load",
               r_cur_tag, r_mem_addr, r_mem_we ? r_mem_wdata : mem_rdata);
  end
`else
`endif

  assign to_issue_full = r_full;
  assign to_rob        = r_to_rob;
  assign to_rob_tag    = r_to_rob_tag;
  assign to_rob_wdata  = r_to_rob_wdata;
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_width     = r_mem_width;

endmodule
